// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD combinational read ports, one
// synchronous write port, a per-register busy scoreboard and a count of
// pending writers.
//
// Optional build macro: REGFILE_BYPASS_EN. When defined, a writeback in the
// current cycle is forwarded to any read port that addresses the same
// register, and that port reports not-busy in the same cycle.
//
// Ports:
//   clk          clock; all state updates on its rising edge
//   reset        synchronous, active-high reset (clears rf, busy, count)
//   reg_write    writeback enable
//   addr         writeback destination
//   write_reg    writeback data
//   reg_addr     read addresses, port i = [i*AW +: AW]
//   rd           read data, port i = [i*XLEN +: XLEN]
//   rd_busy      per-port busy flag of the addressed register
//   issue_valid  request to mark issue_addr busy
//   issue_addr   destination of the instruction being issued
//   issue_ready  issue_addr is free (x0 is always free)
//   busy_vec     full scoreboard, bit 0 always 0
//   pending_cnt  number of set bits in busy_vec

// One read port: x0 returns zero; optional write-to-read forwarding.
module regfile_sb_rdport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] rf,
  input  logic [NREGS-1:0]           busy,
  input  logic [AW-1:0]              raddr,
  input  logic                       wr_en,
  input  logic [AW-1:0]              waddr,
  input  logic [XLEN-1:0]            wdata,
  output logic [XLEN-1:0]            rd,
  output logic                       rd_busy
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd      = (raddr == '0) ? '0 : rf[raddr];
    rd_busy = busy[raddr];
    // Writeback in flight to the register being read: hand the new value
    // straight through; the register is no longer pending from this view.
    if (wr_en && (waddr != '0) && (raddr == waddr)) begin
      rd      = wdata;
      rd_busy = 1'b0;
    end
  end
`else
  always_comb begin
    rd      = (raddr == '0) ? '0 : rf[raddr];
    rd_busy = busy[raddr];
  end

  // Write-side inputs only matter for forwarding.
  logic unused_wr;
  assign unused_wr = ^{wr_en, waddr, wdata};
`endif

endmodule

module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_write,
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     write_reg,
  input  logic [NRD*AW-1:0]   reg_addr,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  output logic                issue_ready,
  output logic [NREGS-1:0]    busy_vec,
  output logic [AW:0]         pending_cnt
);

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [NREGS-1:0]           busy;
  logic [AW:0]                cnt;

  logic wr_hit;    // writeback to a real register
  logic fire_set;  // issue actually marks a register busy
  logic fire_clr;  // writeback actually retires a pending writer

  assign wr_hit      = reg_write && (addr != '0);
  assign issue_ready = (issue_addr == '0) || !busy[issue_addr];
  assign fire_set    = issue_valid && issue_ready && (issue_addr != '0);
  // A same-edge issue to the written register keeps the bit set, so that
  // writeback does not reduce the count. (It can only happen when the bit
  // was clear anyway, but the guard keeps the count tied to busy.)
  assign fire_clr    = wr_hit && busy[addr] && !(fire_set && (issue_addr == addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      rf <= '0;
    end else if (wr_hit) begin
      rf[addr] <= write_reg;
    end
  end

  // Clear first, then set: a same-edge issue to the written register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_hit)   busy[addr]       <= 1'b0;
      if (fire_set) busy[issue_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + (AW+1)'(fire_set) - (AW+1)'(fire_clr);
  end

  assign busy_vec    = busy;
  assign pending_cnt = cnt;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_rdport (
      .rf     (rf),
      .busy   (busy),
      .raddr  (reg_addr[i*AW +: AW]),
      .wr_en  (reg_write),
      .waddr  (addr),
      .wdata  (write_reg),
      .rd     (rd[i*XLEN +: XLEN]),
      .rd_busy(rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                reg_write;
  logic [AW-1:0]       addr;
  logic [XLEN-1:0]     write_reg;
  logic [NRD*AW-1:0]   reg_addr;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                issue_ready;
  logic [NREGS-1:0]    busy_vec;
  logic [AW:0]         pending_cnt;

  int errors = 0;
  int checks = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .addr(addr),
    .write_reg(write_reg), .reg_addr(reg_addr), .rd(rd), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    bit              iv;
    logic [AW-1:0]   ia;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    bit              rdy;   // expected issue_ready (pre-edge)
    logic [XLEN-1:0] rd0;   // expected rd port 0 (pre-edge)
    logic [XLEN-1:0] rd1;
    logic [1:0]      rdb;   // expected rd_busy (pre-edge)
    logic [31:0]     bv;    // expected busy_vec after the edge
    logic [5:0]      cnt;   // expected pending_cnt after the edge
  } vec_t;

  vec_t tbl [10];

  // reference model
  logic [XLEN-1:0] m_rf   [NREGS];
  bit              m_busy [NREGS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; reg_write = 1'b0; addr = '0; write_reg = '0;
    issue_valid = 1'b0; issue_addr = '0; reg_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      m_rf[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  initial begin
    idle();

    // ---- reset, then read a few addresses ----
    do_reset();
    reg_addr = {5'd1, 5'd0};
    #1;
    chk("rst_rd0_x0", rd[31:0], 0);
    chk("rst_rd1_r1", rd[63:32], 0);
    chk("rst_rdbusy", rd_busy, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_cnt", pending_cnt, 0);
    reg_addr = {5'd31, 5'd31};
    #1;
    chk("rst_rd_r31", rd, 0);

    // ---- table: write/x0, scoreboard, collisions ----
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'h0, 32'h0, 2'b00, 32'h0, 6'd0};
    tbl[1] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 6'd0};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5, 1'b1, 32'h0, 32'hDEADBEEF, 2'b00, 32'h80, 6'd1};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 32'h0, 32'h0, 2'b11, 32'h80, 6'd1};
    tbl[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 6'd0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0, 6'd0};
    tbl[6] = '{1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 32'h0, 32'h0, 2'b00, 32'h200, 6'd1};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd9, 5'd4, 1'b1, 32'h55, 32'h0, 2'b01, 32'h210, 6'd2};
    tbl[8] = '{1'b1, 5'd4, 32'h77, 1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 32'h55, 32'h0, 2'b01, 32'h208, 6'd2};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd3, 5'd4, 1'b1, 32'h0, 32'h77, 2'b01, 32'h208, 6'd2};

    for (int i = 0; i < 10; i++) begin
      reg_write = tbl[i].we; addr = tbl[i].wa; write_reg = tbl[i].wd;
      issue_valid = tbl[i].iv; issue_addr = tbl[i].ia;
      reg_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("tbl%0d_ready", i), issue_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_rd0", i), rd[31:0], tbl[i].rd0);
      chk($sformatf("tbl%0d_rd1", i), rd[63:32], tbl[i].rd1);
      chk($sformatf("tbl%0d_rdbusy", i), rd_busy, tbl[i].rdb);
      tick();
      idle();
      chk($sformatf("tbl%0d_busy_vec", i), busy_vec, tbl[i].bv);
      chk($sformatf("tbl%0d_cnt", i), pending_cnt, tbl[i].cnt);
    end

    // ---- forwarding: r10 busy, written while being read ----
    issue_valid = 1'b1; issue_addr = 5'd10;
    tick();
    idle();
    reg_write = 1'b1; addr = 5'd10; write_reg = 32'h0BADF00D;
    reg_addr = {5'd10, 5'd10};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_rd", rd, {32'h0BADF00D, 32'h0BADF00D});
    chk("byp_same_busy", rd_busy, 2'b00);
`else
    chk("byp_same_rd", rd, 64'h0);
    chk("byp_same_busy", rd_busy, 2'b11);
`endif
    tick();
    idle();
    reg_addr = {5'd0, 5'd10};
    #1;
    chk("byp_next_rd", rd[31:0], 32'h0BADF00D);
    chk("byp_next_busy", rd_busy, 2'b00);
    chk("byp_cnt", pending_cnt, 2);

    // ---- reset mid-flight (r3, r9 already pending) ----
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1'b1; issue_addr = AW'(r);
      tick();
    end
    idle();
    chk("mid_pre_cnt", pending_cnt, 4);
    chk("mid_pre_vec", busy_vec, 32'h20E);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reg_addr = {5'd9, 5'd5};
    #1;
    chk("mid_vec", busy_vec, 0);
    chk("mid_cnt", pending_cnt, 0);
    chk("mid_rd", rd, 0);
    reg_write = 1'b1; addr = 5'd2; write_reg = 32'hCAFE0002;
    tick();
    idle();
    reg_addr = {5'd0, 5'd2};
    #1;
    chk("mid_wb_rd", rd[31:0], 32'hCAFE0002);
    chk("mid_wb_cnt", pending_cnt, 0);
    chk("mid_wb_vec", busy_vec, 0);

    // ---- randomized against the reference model ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0]   ra [NRD];
      logic [XLEN-1:0] e_rd;
      bit              e_b, e_rdy;
      reg_write   = 1'($urandom_range(0, 1));
      addr        = AW'($urandom_range(0, 7));
      write_reg   = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = AW'($urandom_range(0, 7));
      ra[0]       = AW'($urandom_range(0, 7));
      ra[1]       = AW'($urandom_range(0, 7));
      reg_addr    = {ra[1], ra[0]};
      reset       = ($urandom_range(0, 59) == 0);
      #1;
      for (int p = 0; p < NRD; p++) begin
        e_rd = (ra[p] == 0) ? '0 : m_rf[ra[p]];
        e_b  = m_busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && addr != 0 && ra[p] == addr) begin
          e_rd = write_reg;
          e_b  = 1'b0;
        end
`endif
        chk($sformatf("rnd%0d_rd%0d", n, p), rd[p*XLEN +: XLEN], e_rd);
        chk($sformatf("rnd%0d_rdbusy%0d", n, p), rd_busy[p], e_b);
      end
      e_rdy = (issue_addr == 0) || !m_busy[issue_addr];
      chk($sformatf("rnd%0d_ready", n), issue_ready, e_rdy);
      // model update at the edge
      if (reset) begin
        for (int r = 0; r < NREGS; r++) begin
          m_rf[r] = '0;
          m_busy[r] = 1'b0;
        end
      end else begin
        if (reg_write && addr != 0) begin
          m_rf[addr] = write_reg;
          m_busy[addr] = 1'b0;
        end
        if (issue_valid && e_rdy && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
      tick();
      chk($sformatf("rnd%0d_vec", n), busy_vec, m_vec());
      chk($sformatf("rnd%0d_cnt", n), pending_cnt, m_pop());
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
